// File: rtl/thread_pc_sequencer.sv
// ---------------------------------------------------------------------------
// Module  : thread_pc_sequencer
// Brief   : Round-robin thread issue sequencer: PC read, fetch handshake,
//           PC writeback. Optional macro PC_WRAP_TRAP_EN adds wrap_trap.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module thread_pc_sequencer #(
  parameter int NTHREADS = 32,
  parameter int PCW      = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [NTHREADS-1:0] thread_ready,
  output logic [4:0]          rthreadid,
  input  logic [PCW-1:0]      qpc,
  output logic [4:0]          wthreadid,
  output logic [PCW-1:0]      dpc,
  output logic                wepc,
  output logic                fetch_req,
  output logic [PCW-1:0]      fetch_addr,
  output logic [4:0]          fetch_tid,
  input  logic                fetch_ack,
  input  logic                redirect,
  input  logic [PCW-1:0]      redirect_pc,
  output logic                issue_valid
`ifdef PC_WRAP_TRAP_EN
  ,
  output logic                wrap_trap
`endif
);

  localparam int TIDW = 5;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] FETCH = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [TIDW-1:0] last_tid;
  logic [TIDW-1:0] pick;
  logic [TIDW-1:0] idx;
  logic            found;
  logic            start;
  logic [PCW-1:0]  pc_r;
  logic [PCW-1:0]  next_pc;
  logic            wrap;
`ifdef PC_WRAP_TRAP_EN
  logic            trap_flag;
`endif

  // Scan last_tid+1 .. last_tid+32; the 5-bit add wraps naturally.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NTHREADS; i++) begin
      idx = last_tid + TIDW'(i);
      if (!found && thread_ready[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign start = run && found;
  assign wrap  = !redirect && (pc_r == '1);

`ifdef PC_WRAP_TRAP_EN
  // A thread that runs off the top of PC space halts on its last PC.
  assign next_pc = redirect ? redirect_pc : (wrap ? pc_r : pc_r + 1'b1);
`else
  assign next_pc = redirect ? redirect_pc : pc_r + 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = LATCH;
      LATCH:   state_nxt = FETCH;
      FETCH:   if (fetch_ack) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fetch_req   = 1'b0;
    wepc        = 1'b0;
    issue_valid = 1'b0;
`ifdef PC_WRAP_TRAP_EN
    wrap_trap   = 1'b0;
`endif
    case (state)
      FETCH: fetch_req = 1'b1;
      WRITE: begin
        wepc        = 1'b1;
        issue_valid = 1'b1;
`ifdef PC_WRAP_TRAP_EN
        wrap_trap   = trap_flag;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rthreadid  <= '0;
      wthreadid  <= '0;
      fetch_tid  <= '0;
      fetch_addr <= '0;
      dpc        <= '0;
      pc_r       <= '0;
      last_tid   <= '1;
`ifdef PC_WRAP_TRAP_EN
      trap_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:  if (start) rthreadid <= pick;
        LATCH: begin
          pc_r       <= qpc;
          fetch_addr <= qpc;
          fetch_tid  <= rthreadid;
        end
        FETCH: if (fetch_ack) begin
          wthreadid <= fetch_tid;
          dpc       <= next_pc;
`ifdef PC_WRAP_TRAP_EN
          trap_flag <= wrap;
`endif
        end
        WRITE: last_tid <= fetch_tid;
        default: ;
      endcase
    end
  end

`ifndef PC_WRAP_TRAP_EN
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_thread_pc_sequencer.sv
// ---------------------------------------------------------------------------
// Module  : tb_thread_pc_sequencer
// Brief   : Directed + randomized bench with a PC register file environment
//           and a round-robin reference model. Honours PC_WRAP_TRAP_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_thread_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] ready;
  logic [4:0]  rthreadid;
  logic [11:0] qpc;
  logic [4:0]  wthreadid;
  logic [11:0] dpc;
  logic        wepc;
  logic        fetch_req;
  logic [11:0] fetch_addr;
  logic [4:0]  fetch_tid;
  logic        fetch_ack;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        issue_valid;
`ifdef PC_WRAP_TRAP_EN
  logic        wrap_trap;
`endif

  thread_pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .thread_ready (ready),
    .rthreadid    (rthreadid),
    .qpc          (qpc),
    .wthreadid    (wthreadid),
    .dpc          (dpc),
    .wepc         (wepc),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_tid    (fetch_tid),
    .fetch_ack    (fetch_ack),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .issue_valid  (issue_valid)
`ifdef PC_WRAP_TRAP_EN
    ,
    .wrap_trap    (wrap_trap)
`endif
  );

  always #5 clk = ~clk;

  // Environment: PC register file with one-clock read latency.
  logic [11:0] rf [32];
  logic        seed_en = 1'b0;
  logic [4:0]  seed_tid = '0;
  logic [11:0] seed_val = '0;
  int          wepc_cnt = 0;
  int          iv_cnt = 0;
  int          req_cnt = 0;

  always @(posedge clk) begin
    qpc <= rf[rthreadid];
    if (wepc) rf[wthreadid] <= dpc;
    if (seed_en) rf[seed_tid] <= seed_val;
    if (wepc) wepc_cnt <= wepc_cnt + 1;
    if (issue_valid) iv_cnt <= iv_cnt + 1;
    if (fetch_req) req_cnt <= req_cnt + 1;
  end

  // Reference model state
  logic [11:0] model_pc [32];
  logic [4:0]  model_last;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic seed(input logic [4:0] t, input logic [11:0] v);
    seed_en  = 1'b1;
    seed_tid = t;
    seed_val = v;
    model_pc[t] = v;
    @(posedge clk);
    #1 seed_en = 1'b0;
  endtask

  // One complete instruction: expected thread from round-robin over 'ready'.
  task automatic issue(input int dly, input bit redir, input logic [11:0] rpc);
    logic [4:0]  t;
    logic [11:0] pc;
    logic [11:0] exp_dpc;
    bit          exp_trap;
    int          n;
    t = model_last;
    do t = t + 5'd1; while (!ready[t]);
    pc = model_pc[t];
    n = 0;
    while (!fetch_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!fetch_req) begin
      chk("fetch_req_timeout", 32'd0, 32'd1);
      return;
    end
    chk("fetch_tid", 32'(fetch_tid), 32'(t));
    chk("fetch_addr", 32'(fetch_addr), 32'(pc));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("req_held", 32'(fetch_req), 32'd1);
      chk("addr_stable", 32'({wepc, fetch_tid, fetch_addr}), 32'({1'b0, t, pc}));
    end
    fetch_ack   = 1'b1;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
    fetch_ack = 1'b0;
    redirect  = 1'b0;
    exp_trap  = !redir && (pc == 12'hFFF);
`ifdef PC_WRAP_TRAP_EN
    exp_dpc = redir ? rpc : (exp_trap ? 12'hFFF : pc + 12'd1);
    chk("wrap_trap", 32'(wrap_trap), 32'(exp_trap));
`else
    exp_dpc = redir ? rpc : pc + 12'd1;
`endif
    chk("wb_strobes", 32'({wepc, issue_valid, fetch_req}), 32'b110);
    chk("wthreadid", 32'(wthreadid), 32'(t));
    chk("dpc", 32'(dpc), 32'(exp_dpc));
    model_pc[t] = exp_dpc;
    model_last  = t;
  endtask

  initial begin
    int w0;
    int i0;
    int r0;
    rst = 1'b1; run = 1'b0; ready = '0;
    fetch_ack = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_last = 5'd31;
    for (int t = 0; t < 32; t++) seed(5'(t), 12'h000);

    // Reset state and idle behaviour with nothing ready
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ids", 32'({rthreadid, wthreadid, fetch_tid}), 32'd0);
    chk("reset_data", 32'({dpc, fetch_addr}), 32'd0);
    chk("reset_strobes", 32'({wepc, fetch_req, issue_valid}), 32'd0);
    run = 1'b1;
    w0 = wepc_cnt; r0 = req_cnt;
    repeat (20) @(negedge clk);
    chk("idle_no_req", 32'(req_cnt - r0), 32'd0);
    chk("idle_no_wepc", 32'(wepc_cnt - w0), 32'd0);

    // Two ready threads alternate
    seed(5'd0, 12'h100);
    seed(5'd5, 12'h2A0);
    ready = 32'h21;
    repeat (3) issue(0, 1'b0, 12'h000);

    // All threads ready: full rotation plus wrap back to thread 0
    ready = '1;
    @(posedge clk);
    #1 i0 = iv_cnt;
    repeat (33) issue(0, 1'b0, 12'h000);
    @(posedge clk);
    #1 chk("issue_valid_count", 32'(iv_cnt - i0), 32'd33);

    // Delayed ack with redirect
    ready = 32'h1 << 3;
    seed(5'd3, 12'h040);
    w0 = wepc_cnt;
    issue(7, 1'b1, 12'hABC);
    @(posedge clk);
    #1 chk("redirect_wepc_once", 32'(wepc_cnt - w0), 32'd1);

    // PC wrap on the last address
    ready = 32'h1 << 31;
    seed(5'd31, 12'hFFF);
    issue(0, 1'b0, 12'h000);

    // Reset in the middle of a fetch
    ready = 32'h1 << 7;
    seed(5'd7, 12'h333);
    for (int n = 0; n < 40 && !fetch_req; n++) @(negedge clk);
    chk("pre_reset_req", 32'(fetch_req), 32'd1);
    w0 = wepc_cnt;
    rst = 1'b1;
    #1 chk("reset_drops_req", 32'({fetch_req, wepc}), 32'd0);
    ready = 32'h81;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last = 5'd31;
    chk("no_wepc_on_abort", 32'(wepc_cnt - w0), 32'd0);
    chk("aborted_pc_kept", 32'(rf[7]), 32'h333);
    issue(0, 1'b0, 12'h000);
    issue(1, 1'b0, 12'h000);

    // Randomized traffic
    for (int k = 0; k < 20; k++) begin
      ready = $urandom();
      if (ready == 0) ready = 32'h1 << $urandom_range(0, 31);
      issue(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 12'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
